// File: rtl/vtpu_vreg_stream.sv
// vtpu_vreg_stream
//   Vector register file with per-row N:M sparsity metadata and a command-driven
//   row-streaming read engine that feeds the systolic array front end.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   wr_en/wr_reg/wr_row   row write strobe and address
//   wr_data, wr_meta      row payload (element i at [i*BITWIDTH +: BITWIDTH]) and metadata
//   cmd_*                 stream command: source register, first row, row count
//                         (0 = all NUM_REG_ROWS rows), FP6 packing select
//   out_*                 streamed beats: payload, metadata, last-beat flag
//   busy                  high while a command is streaming
//
// Handshake semantics (both the cmd and out channels):
//   A transfer happens on a rising clk edge where valid && ready are both high.
//   Once out_valid is raised it stays high, and out_data/out_meta/out_last stay
//   stable, until the beat transfers. cmd_ready is high in IDLE and during the
//   cycle in which the final beat of the current command transfers, so commands
//   can be chained with no idle cycle between them.
module vtpu_vreg_stream #(
    parameter int NUM_REGS             = 8,
    parameter int NUM_REG_ROWS         = 16,
    parameter int NUM_REG_COLUMNS      = 64,
    parameter int BITWIDTH             = 8,
    parameter int FP6_WIDTH            = 6,
    parameter int NUM_META_REG_COLUMNS = 32,
    parameter int META_DATA_SIZE       = 2,
    localparam int RW = NUM_REG_COLUMNS * BITWIDTH,
    localparam int MW = NUM_META_REG_COLUMNS * META_DATA_SIZE,
    localparam int RA = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int RO = (NUM_REG_ROWS > 1) ? $clog2(NUM_REG_ROWS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [RA-1:0] wr_reg,
    input  logic [RO-1:0] wr_row,
    input  logic [RW-1:0] wr_data,
    input  logic [MW-1:0] wr_meta,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [RA-1:0] cmd_reg,
    input  logic [RO-1:0] cmd_start_row,
    input  logic [RO-1:0] cmd_num_rows,
    input  logic          cmd_fp6,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_data,
    output logic [MW-1:0] out_meta,
    output logic          out_last,
    output logic          busy
);

    // Remaining-beat counter must be able to hold NUM_REG_ROWS itself.
    localparam int CW = $clog2(NUM_REG_ROWS + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Storage: plain flops, intentionally not reset.
    logic [RW-1:0] data_mem [NUM_REGS][NUM_REG_ROWS];
    logic [MW-1:0] meta_mem [NUM_REGS][NUM_REG_ROWS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_reg][wr_row] <= wr_data;
            meta_mem[wr_reg][wr_row] <= wr_meta;
        end
    end

    state_t        state_q, state_d;
    logic [RA-1:0] reg_q, reg_d;
    logic [RO-1:0] ptr_q, ptr_d;       // next row to load after the one on the output
    logic [CW-1:0] rem_q, rem_d;       // beats left, including the one on the output
    logic          fmt_q, fmt_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [RW-1:0] out_data_q, out_data_d;
    logic [MW-1:0] out_meta_q, out_meta_d;

    function automatic logic [RO-1:0] next_row(input logic [RO-1:0] r);
        return (r == RO'(NUM_REG_ROWS - 1)) ? '0 : r + RO'(1);
    endfunction

    // Low FP6_WIDTH bits of every element, packed densely from bit 0; the
    // unused upper part of the row stays zero.
    function automatic logic [RW-1:0] pack_row(input logic [RW-1:0] raw, input logic fp6);
        logic [RW-1:0] packed_row;
        packed_row = '0;
        if (fp6) begin
            for (int i = 0; i < NUM_REG_COLUMNS; i++) begin
                packed_row[i*FP6_WIDTH +: FP6_WIDTH] = raw[i*BITWIDTH +: FP6_WIDTH];
            end
        end else begin
            packed_row = raw;
        end
        return packed_row;
    endfunction

    logic          xfer;
    logic          accept;
    logic [CW-1:0] cmd_len;
    logic [RA-1:0] ld_reg;
    logic [RO-1:0] ld_row;
    logic          ld_fmt;
    logic          ld_hit;
    logic [RW-1:0] ld_data;
    logic [MW-1:0] ld_meta;

    assign xfer      = out_valid_q && out_ready;
    assign cmd_ready = (state_q == IDLE) || (xfer && (rem_q == CW'(1)));
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_len   = (cmd_num_rows == '0) ? CW'(NUM_REG_ROWS) : CW'(cmd_num_rows);

    // Row being loaded into the output register this edge: the new command's
    // first row on accept, otherwise the next row of the running command.
    // A same-edge write to that row is forwarded so the beat sees the new data.
    always_comb begin
        ld_reg  = accept ? cmd_reg       : reg_q;
        ld_row  = accept ? cmd_start_row : ptr_q;
        ld_fmt  = accept ? cmd_fp6       : fmt_q;
        ld_hit  = wr_en && (wr_reg == ld_reg) && (wr_row == ld_row);
        ld_data = pack_row(ld_hit ? wr_data : data_mem[ld_reg][ld_row], ld_fmt);
        ld_meta = ld_hit ? wr_meta : meta_mem[ld_reg][ld_row];
    end

    always_comb begin
        state_d     = state_q;
        reg_d       = reg_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        fmt_d       = fmt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_meta_d  = out_meta_q;
        if (accept) begin
            state_d     = STREAM;
            reg_d       = cmd_reg;
            fmt_d       = cmd_fp6;
            ptr_d       = next_row(cmd_start_row);
            rem_d       = cmd_len;
            out_valid_d = 1'b1;
            out_last_d  = (cmd_len == CW'(1));
            out_data_d  = ld_data;
            out_meta_d  = ld_meta;
        end else if (state_q == STREAM && xfer) begin
            if (rem_q > CW'(1)) begin
                ptr_d      = next_row(ptr_q);
                rem_d      = rem_q - CW'(1);
                out_last_d = (rem_q == CW'(2));
                out_data_d = ld_data;
                out_meta_d = ld_meta;
            end else begin
                state_d     = IDLE;
                rem_d       = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            reg_q       <= '0;
            ptr_q       <= '0;
            rem_q       <= '0;
            fmt_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_meta_q  <= '0;
        end else begin
            state_q     <= state_d;
            reg_q       <= reg_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            fmt_q       <= fmt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_meta_q  <= out_meta_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign out_meta  = out_meta_q;
    assign busy      = (state_q == STREAM);

endmodule

// File: tb/tb_vtpu_vreg_stream.sv
// Bench for vtpu_vreg_stream: random register contents and commands checked
// against a row-level model of the register file and the streaming rules.
module tb_vtpu_vreg_stream;

    localparam int NR = 8;
    localparam int NROWS = 16;
    localparam int NCOL = 64;
    localparam int RW = 512;
    localparam int MW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_reg = '0;
    logic [3:0]    wr_row = '0;
    logic [RW-1:0] wr_data = '0;
    logic [MW-1:0] wr_meta = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_reg = '0;
    logic [3:0]    cmd_start_row = '0;
    logic [3:0]    cmd_num_rows = '0;
    logic          cmd_fp6 = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] out_data;
    logic [MW-1:0] out_meta;
    logic          out_last;
    logic          busy;

    vtpu_vreg_stream dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_row(wr_row), .wr_data(wr_data), .wr_meta(wr_meta),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reg(cmd_reg),
        .cmd_start_row(cmd_start_row), .cmd_num_rows(cmd_num_rows), .cmd_fp6(cmd_fp6),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_meta(out_meta), .out_last(out_last), .busy(busy)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: what the register file should hold.
    logic [RW-1:0] m_data [NR][NROWS];
    logic [MW-1:0] m_meta [NR][NROWS];

    // Scoreboard: expected beats of the current command, and beats observed.
    logic [RW-1:0] exp_q [$];
    logic [MW-1:0] exp_meta_q [$];
    logic          exp_last_q [$];
    logic [RW-1:0] got_data [$];
    logic [MW-1:0] got_meta [$];
    logic          got_last [$];
    int            got_cyc [$];
    int            hold_err;

    function automatic logic [RW-1:0] ref_data(input int rg, input int row, input bit fp6);
        logic [RW-1:0] src, r;
        src = m_data[rg][row];
        r = '0;
        for (int i = 0; i < NCOL; i++) begin
            if (fp6) r = r | (RW'(src[i*8 +: 6]) << (i * 6));
            else     r = r | (RW'(src[i*8 +: 8]) << (i * 8));
        end
        return r;
    endfunction

    task automatic build_exp(input int rg, input int start, input int num, input bit fp6);
        int n;
        exp_q.delete(); exp_meta_q.delete(); exp_last_q.delete();
        n = (num == 0) ? NROWS : num;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(ref_data(rg, (start + k) % NROWS, fp6));
            exp_meta_q.push_back(m_meta[rg][(start + k) % NROWS]);
            exp_last_q.push_back(k == n - 1);
        end
    endtask

    // Driver: one row write, model updated alongside.
    task automatic write_row(input int rg, input int row, input logic [RW-1:0] d, input logic [MW-1:0] m);
        @(negedge clk);
        wr_en = 1'b1; wr_reg = 3'(rg); wr_row = 4'(row); wr_data = d; wr_meta = m;
        m_data[rg][row] = d;
        m_meta[rg][row] = m;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    // Driver: present a command for one edge (DUT must be idle).
    task automatic issue_cmd(input int rg, input int start, input int num, input bit fp6);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_reg = 3'(rg); cmd_start_row = 4'(start);
        cmd_num_rows = 4'(num); cmd_fp6 = fp6; out_ready = 1'b1;
        @(posedge clk);
    endtask

    // Monitor: collect beats until the last one transfers or the budget runs out.
    // cmd_fp6 is scrambled every cycle; the running command must ignore it.
    task automatic collect(input int max_cycles, input int stall_pct);
        logic [RW-1:0] hd;
        logic [MW-1:0] hm;
        logic          hl;
        logic          held;
        got_data.delete(); got_meta.delete(); got_last.delete(); got_cyc.delete();
        hold_err = 0;
        held = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0; wr_en = 1'b0;
            cmd_fp6 = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 99) >= stall_pct);
            #1;
            if (held && (out_valid !== 1'b1 || out_data !== hd || out_meta !== hm || out_last !== hl))
                hold_err++;
            if (out_valid === 1'b1 && busy !== 1'b1) hold_err++;
            held = out_valid && !out_ready;
            hd = out_data; hm = out_meta; hl = out_last;
            if (out_valid === 1'b1 && out_ready) begin
                got_data.push_back(out_data);
                got_meta.push_back(out_meta);
                got_last.push_back(out_last);
                got_cyc.push_back(c);
                if (out_last === 1'b1) break;
            end
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        n_checks++; if (out_meta !== '0) begin n_fail++; $display("FAIL reset_out_meta got=%h want=0", out_meta); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        rst = 1'b0;
    endtask

    task automatic fill_all();
        logic [RW-1:0] d;
        logic [MW-1:0] m;
        for (int rg = 0; rg < NR; rg++)
            for (int row = 0; row < NROWS; row++) begin
                for (int w = 0; w < RW / 32; w++) d[w*32 +: 32] = $urandom;
                m = {$urandom, $urandom};
                write_row(rg, row, d, m);
            end
        // Register 3: element i of row r is r*4+i, metadata is the row index repeated.
        for (int row = 0; row < NROWS; row++) begin
            for (int i = 0; i < NCOL; i++) d[i*8 +: 8] = 8'((row * 4 + i) % 256);
            m = {16{4'(row)}};
            write_row(3, row, d, m);
        end
    endtask

    task automatic test_full_stream();
        build_exp(3, 0, 16, 0);
        issue_cmd(3, 0, 16, 0);
        collect(40, 0);
        n_checks++; if (got_data.size() !== 16) begin n_fail++; $display("FAIL full_count got=%0d want=16", got_data.size()); end
        for (int k = 0; k < got_data.size() && k < 16; k++) begin
            n_checks++; if (got_data[k] !== exp_q[k]) begin n_fail++; $display("FAIL full_data beat %0d got=%h want=%h", k, got_data[k], exp_q[k]); end
            n_checks++; if (got_meta[k] !== exp_meta_q[k]) begin n_fail++; $display("FAIL full_meta beat %0d got=%h want=%h", k, got_meta[k], exp_meta_q[k]); end
            n_checks++; if (got_last[k] !== exp_last_q[k]) begin n_fail++; $display("FAIL full_last beat %0d got=%b want=%b", k, got_last[k], exp_last_q[k]); end
            n_checks++; if (got_cyc[k] !== k) begin n_fail++; $display("FAIL full_timing beat %0d cycle got=%0d want=%0d", k, got_cyc[k], k); end
        end
        @(negedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after got=%b want=0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_valid_after got=%b want=0", out_valid); end
    endtask

    task automatic test_wrap();
        logic [RW-1:0] d;
        build_exp(3, 14, 4, 0);
        issue_cmd(3, 14, 4, 0);
        collect(20, 0);
        n_checks++; if (got_data.size() !== 4) begin n_fail++; $display("FAIL wrap_count got=%0d want=4", got_data.size()); end
        for (int k = 0; k < got_data.size() && k < 4; k++) begin
            n_checks++; if (got_data[k] !== exp_q[k] || got_meta[k] !== exp_meta_q[k] || got_last[k] !== exp_last_q[k])
                begin n_fail++; $display("FAIL wrap_beat %0d got=%h/%h/%b want=%h/%h/%b", k, got_data[k][63:0], got_meta[k], got_last[k], exp_q[k][63:0], exp_meta_q[k], exp_last_q[k]); end
        end
        // Row 1's element 0 is 4, so the last beat's first byte must be 4.
        d = (got_data.size() == 4) ? got_data[3] : '0;
        n_checks++; if (d[7:0] !== 8'd4) begin n_fail++; $display("FAIL wrap_last_row got=%h want=04", d[7:0]); end
        build_exp(5, 7, 0, 0);
        issue_cmd(5, 7, 0, 0);
        collect(40, 0);
        n_checks++; if (got_data.size() !== 16) begin n_fail++; $display("FAIL num0_count got=%0d want=16", got_data.size()); end
        for (int k = 0; k < got_data.size() && k < 16; k++) begin
            n_checks++; if (got_data[k] !== exp_q[k] || got_meta[k] !== exp_meta_q[k] || got_last[k] !== exp_last_q[k])
                begin n_fail++; $display("FAIL num0_beat %0d got_last=%b want_last=%b", k, got_last[k], exp_last_q[k]); end
        end
    endtask

    task automatic test_stall();
        int rg, st, num, n;
        bit fp6;
        for (int it = 0; it < 8; it++) begin
            rg = $urandom_range(0, NR - 1);
            st = $urandom_range(0, NROWS - 1);
            num = $urandom_range(0, NROWS - 1);
            fp6 = 1'($urandom_range(0, 1));
            n = (num == 0) ? NROWS : num;
            build_exp(rg, st, num, fp6);
            issue_cmd(rg, st, num, fp6);
            collect(300, 50);
            n_checks++; if (hold_err !== 0) begin n_fail++; $display("FAIL stall_hold iter %0d errors=%0d want=0", it, hold_err); end
            n_checks++; if (got_data.size() !== n) begin n_fail++; $display("FAIL stall_count iter %0d got=%0d want=%0d", it, got_data.size(), n); end
            for (int k = 0; k < got_data.size() && k < n; k++) begin
                n_checks++; if (got_data[k] !== exp_q[k] || got_meta[k] !== exp_meta_q[k] || got_last[k] !== exp_last_q[k])
                    begin n_fail++; $display("FAIL stall_beat iter %0d beat %0d got=%h want=%h", it, k, got_data[k][63:0], exp_q[k][63:0]); end
            end
        end
    endtask

    task automatic test_fp6();
        logic [RW-1:0] d, b;
        write_row(1, 2, '1, 64'h0123_4567_89AB_CDEF);
        for (int w = 0; w < RW / 32; w++) d[w*32 +: 32] = $urandom;
        d[7*8 +: 8] = 8'h2A;
        write_row(1, 3, d, 64'hFEDC_BA98_7654_3210);
        build_exp(1, 2, 2, 1);
        issue_cmd(1, 2, 2, 1);
        collect(20, 0);
        n_checks++; if (got_data.size() !== 2) begin n_fail++; $display("FAIL fp6_count got=%0d want=2", got_data.size()); end
        b = (got_data.size() > 0) ? got_data[0] : '0;
        n_checks++; if (b[383:0] !== {384{1'b1}}) begin n_fail++; $display("FAIL fp6_ones_low got=%h", b[383:0]); end
        n_checks++; if (b[511:384] !== 128'd0) begin n_fail++; $display("FAIL fp6_zero_high got=%h want=0", b[511:384]); end
        b = (got_data.size() > 1) ? got_data[1] : '0;
        n_checks++; if (b[7*6 +: 6] !== 6'h2A) begin n_fail++; $display("FAIL fp6_elem7 got=%h want=2a", b[7*6 +: 6]); end
        for (int k = 0; k < got_data.size() && k < 2; k++) begin
            n_checks++; if (got_data[k] !== exp_q[k] || got_meta[k] !== exp_meta_q[k])
                begin n_fail++; $display("FAIL fp6_beat %0d got=%h want=%h", k, got_data[k][127:0], exp_q[k][127:0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [RW-1:0] nd;
        logic [MW-1:0] nm;
        build_exp(3, 0, 2, 0);
        issue_cmd(3, 0, 2, 0);
        @(negedge clk);
        cmd_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin n_fail++; $display("FAIL b2b_a_beat0 valid=%b data=%h", out_valid, out_data[63:0]); end
        @(negedge clk);
        for (int w = 0; w < RW / 32; w++) nd[w*32 +: 32] = $urandom;
        nm = {$urandom, $urandom};
        // Command B accepted on A's last beat; same edge writes the row B loads first.
        cmd_valid = 1'b1; cmd_reg = 3'd3; cmd_start_row = 4'd5; cmd_num_rows = 4'd3; cmd_fp6 = 1'b0;
        wr_en = 1'b1; wr_reg = 3'd3; wr_row = 4'd5; wr_data = nd; wr_meta = nm;
        m_data[3][5] = nd;
        m_meta[3][5] = nm;
        #1;
        n_checks++; if (out_last !== 1'b1 || out_data !== exp_q[1]) begin n_fail++; $display("FAIL b2b_a_last last=%b data=%h", out_last, out_data[63:0]); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_cmd_ready got=%b want=1", cmd_ready); end
        @(posedge clk);
        build_exp(3, 5, 3, 0);
        collect(20, 0);
        n_checks++; if (got_data.size() !== 3) begin n_fail++; $display("FAIL b2b_count got=%0d want=3", got_data.size()); end
        n_checks++; if (got_cyc.size() == 0 || got_cyc[0] !== 0) begin n_fail++; $display("FAIL b2b_gap first beat not in cycle after accept"); end
        for (int k = 0; k < got_data.size() && k < 3; k++) begin
            n_checks++; if (got_data[k] !== exp_q[k] || got_meta[k] !== exp_meta_q[k] || got_last[k] !== exp_last_q[k])
                begin n_fail++; $display("FAIL b2b_beat %0d got=%h want=%h", k, got_data[k][63:0], exp_q[k][63:0]); end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        issue_cmd(3, 0, 16, 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0; out_ready = 1'b1;
            #1;
            if (out_valid === 1'b1) seen++;
        end
        n_checks++; if (seen !== 6) begin n_fail++; $display("FAIL rstmid_pre_beats got=%0d want=6", seen); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_cmd_ready got=%b want=1", cmd_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_beats cycle %0d got=%b want=0", c, out_valid); end
        end
        build_exp(3, 9, 5, 0);
        issue_cmd(3, 9, 5, 0);
        collect(20, 0);
        n_checks++; if (got_data.size() !== 5) begin n_fail++; $display("FAIL rstmid_count got=%0d want=5", got_data.size()); end
        for (int k = 0; k < got_data.size() && k < 5; k++) begin
            n_checks++; if (got_data[k] !== exp_q[k] || got_meta[k] !== exp_meta_q[k] || got_last[k] !== exp_last_q[k])
                begin n_fail++; $display("FAIL rstmid_beat %0d got=%h want=%h", k, got_data[k][63:0], exp_q[k][63:0]); end
        end
    endtask

    initial begin
        test_reset();
        fill_all();
        test_full_stream();
        test_wrap();
        test_stall();
        test_fp6();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vtpu_vreg_stream.md
Name: vtpu_vreg_stream

Overview:
- Parametrised vector register file with metadata registers and a command-driven row-streaming read engine.
- Feeds operand rows and N:M sparsity metadata to the systolic array front end over a valid/ready interface.
- Supports 8-bit passthrough or dense FP6 packing.
- Successor to the fixed 8x16x64 register organisation: geometry, metadata width and element format are all parameters or per-command modes.

Parameters:
- NUM_REGS, 8, number of vector registers.
- NUM_REG_ROWS, 16, rows per register.
- NUM_REG_COLUMNS, 64, elements per row.
- BITWIDTH, 8, stored element width.
- FP6_WIDTH, 6, packed element width in FP6 mode.
- NUM_META_REG_COLUMNS, 32, metadata entries per row.
- META_DATA_SIZE, 2, bits per metadata entry.
- Derived: RW=NUM_REG_COLUMNS*BITWIDTH, MW=NUM_META_REG_COLUMNS*META_DATA_SIZE, RA=$clog2(NUM_REGS), RO=$clog2(NUM_REG_ROWS).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wr_en  in  1  row write strobe
- wr_reg  in  RA  target register
- wr_row  in  RO  target row
- wr_data  in  RW  row data, element i at [i*BITWIDTH +: BITWIDTH]
- wr_meta  in  MW  row metadata
- cmd_valid  in  1  stream command valid
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_reg  in  RA  source register
- cmd_start_row  in  RO  first row
- cmd_num_rows  in  RO  row count; 0 means NUM_REG_ROWS
- cmd_fp6  in  1  1 = FP6 packed output, 0 = 8-bit passthrough
- out_valid  out  1  beat valid
- out_ready  in  1  consumer ready
- out_data  out  RW  row payload
- out_meta  out  MW  row metadata
- out_last  out  1  final beat of command
- busy  out  1  command in progress

Behaviour:
- Storage:
  - NUM_REGS x NUM_REG_ROWS data rows (RW bits) plus metadata rows (MW bits), in flops.
  - Storage is NOT reset; contents are undefined until written.
  - A write takes effect at the clk edge when wr_en=1.
- Reset: out_valid=0, out_last=0, out_data=0, out_meta=0, busy=0, cmd_ready=1, state=IDLE. A reset asserted mid-stream aborts the stream; no further beats are produced.
- FSM states:
  - IDLE: cmd_ready=1. On accept, latch reg, row pointer=start_row, remaining=(num_rows==0 ? NUM_REG_ROWS : num_rows) and fmt; go to STREAM.
  - STREAM: busy=1. The output register holds the current row.
- Latency: command accepted at edge t; first beat has out_valid=1 in the cycle after t.
- Beat handshake:
  - A beat transfers when out_valid&&out_ready.
  - While out_ready=0, out_data, out_meta and out_last are held stable and out_valid stays 1.
  - On transfer with remaining>1: load the next row into the output register in the same edge. No bubbles, one beat per cycle at full throughput.
- Row addressing: row pointer increments modulo NUM_REG_ROWS. Example: start_row=14, num_rows=4 on 16 rows reads 14, 15, 0, 1.
- out_last=1 exactly on the beat where remaining==1.
- Back-to-back commands:
  - cmd_ready=1 in IDLE, or in STREAM during the cycle the last beat transfers.
  - A new command accepted then produces its first beat in the next cycle, with no gap.
  - Otherwise the FSM returns to IDLE and out_valid=0.
- Write/read collision: if wr_en targets the same reg/row that is being loaded into the output register in the same edge, the output register captures wr_data/wr_meta (write-through bypass). Rows already in the output register are not updated by later writes.
- FP6 mode (cmd_fp6=1):
  - out_data[i*FP6_WIDTH +: FP6_WIDTH] = element i bits [FP6_WIDTH-1:0].
  - Bits [NUM_REG_COLUMNS*FP6_WIDTH .. RW-1] are 0.
  - out_meta is unchanged by mode.
- The command mode is latched per command; changes on cmd_fp6 mid-stream are ignored.

Test Plan:
- Write reg 3 rows 0..15 with element i of row r = r*4+i (8-bit, mod 256) and meta = row index replicated. Cmd reg 3, start 0, num 16, fp8, out_ready=1 -> 16 consecutive beats starting the cycle after accept, rows 0..15, out_last only on beat 16, busy drops after.
- Cmd start_row=14, num_rows=4 -> beats carry rows 14, 15, 0, 1; out_last on row 1. Cmd num_rows=0 -> exactly 16 beats.
- Toggle out_ready randomly at 50% -> every beat held stable while stalled, no beat lost or duplicated, order preserved.
- Row holding 0xFF in all elements, cmd_fp6=1 -> out_data low 384 bits all 1, upper 128 bits 0. Element 0x2A maps to 6-bit 0x2A at the correct offset.
- Issue cmd B while cmd A's last beat transfers -> B's first beat on the following cycle, no idle gap. Also write reg 3 row 5 in the same cycle row 5 is loaded -> beat carries the new data.
- Assert rst during beat 7 of 16 -> out_valid=0, busy=0, cmd_ready=1 immediately. After release, a new command streams correctly from its own start row.
